// File: rtl/phalanx_sched_if.sv
// Push channel into the scheduler and the phalanx command bus it drives.
interface phalanx_sched_if #(
  parameter int unsigned nel = 8,
  parameter int unsigned tw  = 24
);
  localparam int unsigned nell = $clog2(nel);

  logic [63:0]     in_cmd;
  logic [nell-1:0] in_elem;
  logic [tw-1:0]   in_time;
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     command;
  logic [nell-1:0] cmda;
  logic            cstrobe;

  modport slave (
    input  in_cmd, in_elem, in_time, in_valid,
    output in_ready, command, cmda, cstrobe
  );

  modport master (
    output in_cmd, in_elem, in_time, in_valid,
    input  in_ready, command, cmda, cstrobe
  );
endinterface

// File: rtl/phalanx_sched.sv
// Timestamped command scheduler: FWFT FIFO of pulse commands released onto the
// phalanx bus when the run timer reaches each command's issue time.
module phalanx_sched #(
  parameter int unsigned nel  = 8,
  parameter int unsigned nell = $clog2(nel),
  parameter int unsigned tw   = 24,
  parameter int unsigned fw   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          flush,
  phalanx_sched_if.slave bus,
  output logic          daczero,
  output logic          running,
  output logic          late,
  output logic          ovf,
  output logic [fw:0]   level
);
  localparam int unsigned Ww     = 64 + nell + tw;
  localparam int unsigned Depth  = 2 ** fw;
  localparam logic [fw:0] DepthL = (fw + 1)'(Depth);
  localparam logic [tw-1:0] TMax = '1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [Ww-1:0]   mem_q [Depth];
  logic [fw-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [fw:0]     count_q, count_d;
  logic [tw-1:0]   timer_q, timer_d;
  logic            late_q, late_d, ovf_q, ovf_d, dacz_q, dacz_d, cstrobe_q, cstrobe_d;
  logic [63:0]     cmd_q, cmd_d;
  logic [nell-1:0] cmda_q, cmda_d;
  logic            push, pop, restart;
  logic [63:0]     head_cmd;
  logic [nell-1:0] head_elem;
  logic [tw-1:0]   head_time;

  assign {head_cmd, head_elem, head_time} = mem_q[rd_ptr_q];
  assign bus.in_ready = ~reset & (count_q < DepthL);
  // flush discards a same-cycle push
  assign push    = bus.in_valid & bus.in_ready & ~flush;
  assign pop     = (state_q == StRun) & (count_q != '0) & (head_time <= timer_q);
  assign restart = start & ~stop;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ovf_d     = ovf_q;
    late_d    = late_q;
    dacz_d    = (state_q != StRun);
    cstrobe_d = pop;
    cmd_d     = cmd_q;
    cmda_d    = cmda_q;
    wr_ptr_d  = wr_ptr_q + fw'(push);
    rd_ptr_d  = rd_ptr_q + fw'(pop);
    count_d   = count_q + (fw + 1)'(push) - (fw + 1)'(pop);

    if (stop) begin
      state_d = StIdle;
    end else if (start) begin
      state_d = StRun;
    end

    if (restart) begin
      timer_d = '0;
      ovf_d   = 1'b0;
    end else if (!stop && state_q == StRun) begin
      if (timer_q == TMax) begin
        ovf_d = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (pop) begin
      cmd_d  = head_cmd;
      cmda_d = head_elem;
    end

    if (restart) begin
      late_d = 1'b0;
    end else if (pop && head_time < timer_q) begin
      late_d = 1'b1;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      ovf_q     <= 1'b0;
      late_q    <= 1'b0;
      dacz_q    <= 1'b1;
      cstrobe_q <= 1'b0;
      cmd_q     <= '0;
      cmda_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ovf_q     <= ovf_d;
      late_q    <= late_d;
      dacz_q    <= dacz_d;
      cstrobe_q <= cstrobe_d;
      cmd_q     <= cmd_d;
      cmda_q    <= cmda_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_cmd, bus.in_elem, bus.in_time};
    end
  end

  assign bus.command = cmd_q;
  assign bus.cmda    = cmda_q;
  assign bus.cstrobe = cstrobe_q;
  assign daczero     = dacz_q;
  assign running     = (state_q == StRun);
  assign late        = late_q;
  assign ovf         = ovf_q;
  assign level       = count_q;
endmodule

// File: tb/tb_phalanx_sched.sv
// Scenario tasks for the phalanx scheduler plus a randomized run against a queue model.
module tb_phalanx_sched;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, stop = 1'b0, flush = 1'b0;
  logic b_start = 1'b0, b_stop = 1'b0, b_flush = 1'b0;
  logic a_dacz, a_run, a_late, a_ovf, b_dacz, b_run, b_late, b_ovf;
  logic [4:0] a_level, b_level;
  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  phalanx_sched_if #(.nel(8), .tw(24)) ifa ();
  phalanx_sched_if #(.nel(8), .tw(4))  ifb ();

  phalanx_sched #(.nel(8), .tw(24), .fw(4)) u_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .flush(flush), .bus(ifa),
    .daczero(a_dacz), .running(a_run), .late(a_late), .ovf(a_ovf), .level(a_level)
  );

  phalanx_sched #(.nel(8), .tw(4), .fw(4)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .flush(b_flush), .bus(ifb),
    .daczero(b_dacz), .running(b_run), .late(b_late), .ovf(b_ovf), .level(b_level)
  );

  // Reference model for DUT A: a queue of pending commands and an integer clock.
  typedef struct {
    logic [63:0] cmd;
    logic [2:0]  elem;
    longint      tm;
  } ent_t;
  localparam longint TMaxA = 64'hFF_FFFF;
  ent_t        mq[$];
  bit          m_run, m_late, m_ovf, m_strobe, m_dacz = 1'b1;
  longint      m_timer;
  logic [63:0] m_cmd;
  logic [2:0]  m_elem;

  task automatic model_update();
    bit   issue, lt, can_push;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_run = 0; m_timer = 0; m_late = 0; m_ovf = 0; m_strobe = 0; m_dacz = 1;
      m_cmd = '0; m_elem = '0;
      return;
    end
    can_push = ifa.in_valid && mq.size() < 16 && !flush;
    issue = m_run && mq.size() > 0 && mq[0].tm <= m_timer;
    m_dacz = !m_run;
    m_strobe = issue;
    lt = 0;
    if (issue) begin
      e = mq.pop_front();
      m_cmd = e.cmd;
      m_elem = e.elem;
      lt = e.tm < m_timer;
    end
    if (flush) mq.delete();
    else if (can_push) begin
      e.cmd = ifa.in_cmd; e.elem = ifa.in_elem; e.tm = longint'(ifa.in_time);
      mq.push_back(e);
    end
    if (stop) m_run = 0;
    else if (start) begin
      m_run = 1; m_timer = 0; m_late = 0; m_ovf = 0;
    end else if (m_run) begin
      if (m_timer == TMaxA) m_ovf = 1;
      else m_timer++;
    end
    if (issue && lt && !(start && !stop)) m_late = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic push_a(input logic [63:0] c, input logic [2:0] el, input logic [23:0] t);
    ifa.in_valid = 1'b1; ifa.in_cmd = c; ifa.in_elem = el; ifa.in_time = t;
    step();
    ifa.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (ifa.in_ready !== 1'b0) $display("FAIL in_ready_during_reset got %b want 0", ifa.in_ready);
    else n_pass++;
    n_checks++;
    if ({a_dacz, a_run, a_late, a_ovf, ifa.cstrobe} !== 5'b10000)
      $display("FAIL reset_flags got %b want 10000", {a_dacz, a_run, a_late, a_ovf, ifa.cstrobe});
    else n_pass++;
    n_checks++;
    if (a_level !== 5'd0 || ifa.command !== 64'd0 || ifa.cmda !== 3'd0)
      $display("FAIL reset_bus got lvl=%0d cmd=%h cmda=%0d want 0", a_level, ifa.command, ifa.cmda);
    else n_pass++;
    reset = 1'b0;
    step();
    n_checks++;
    if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1 || a_dacz !== 1'b1)
      $display("FAIL ready_after_reset got %b%b%b want 111", ifa.in_ready, ifb.in_ready, a_dacz);
    else n_pass++;
  endtask

  task automatic test_order();
    int exp_k[3] = '{11, 12, 21};
    int exp_e[3] = '{2, 5, 7};
    int ks[$];
    int es[$];
    bit ls[$];
    push_a(64'hA0, 3'd2, 24'd10);
    push_a(64'hA1, 3'd5, 24'd10);
    push_a(64'hA2, 3'd7, 24'd20);
    n_checks++;
    if (a_level !== 5'd3) $display("FAIL order_level got %0d want 3", a_level);
    else n_pass++;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (ifa.cstrobe) begin ks.push_back(k); es.push_back(int'(ifa.cmda)); ls.push_back(a_late); end
    end
    n_checks++;
    if (ks.size() != 3) $display("FAIL order_count got %0d want 3", ks.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < ks.size(); i++) begin
      n_checks++;
      if (ks[i] != exp_k[i] || es[i] != exp_e[i])
        $display("FAIL order_issue%0d got k=%0d e=%0d want k=%0d e=%0d", i, ks[i], es[i],
                 exp_k[i], exp_e[i]);
      else n_pass++;
    end
    n_checks++;
    if (ls.size() >= 2 && (ls[0] !== 1'b0 || ls[1] !== 1'b1))
      $display("FAIL order_late got %b%b want 01", ls[0], ls[1]);
    else n_pass++;
    n_checks++;
    if (a_level !== 5'd0 || a_late !== 1'b1)
      $display("FAIL order_end got lvl=%0d late=%b want 0,1", a_level, a_late);
    else n_pass++;
  endtask

  task automatic test_fill();
    int   ks[$];
    logic [63:0] cs[$];
    bit   ok;
    stop = 1'b1; step(); stop = 1'b0;
    for (int i = 0; i < 16; i++) push_a(64'hF00 + 64'(i), 3'(i % 8), 24'd0);
    n_checks++;
    if (ifa.in_ready !== 1'b0 || a_level !== 5'd16)
      $display("FAIL fill_full got rdy=%b lvl=%0d want 0,16", ifa.in_ready, a_level);
    else n_pass++;
    push_a(64'hDEAD, 3'd1, 24'd0);
    n_checks++;
    if (a_level !== 5'd16) $display("FAIL fill_overpush got lvl=%0d want 16", a_level);
    else n_pass++;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (ifa.cstrobe) begin ks.push_back(k); cs.push_back(ifa.command); end
    end
    ok = (ks.size() == 16);
    for (int i = 0; i < ks.size(); i++) if (ks[i] != i + 1 || cs[i] !== 64'hF00 + 64'(i)) ok = 0;
    n_checks++;
    if (!ok) $display("FAIL fill_drain got %0d strobes (first k=%0d) want 16 from k=1",
                      ks.size(), ks.size() > 0 ? ks[0] : -1);
    else n_pass++;
    n_checks++;
    if (ifa.in_ready !== 1'b1 || a_level !== 5'd0)
      $display("FAIL fill_empty got rdy=%b lvl=%0d want 1,0", ifa.in_ready, a_level);
    else n_pass++;
  endtask

  task automatic test_stop_resume();
    int n_str = 0;
    int first_k = -1;
    stop = 1'b1; step(); stop = 1'b0;
    step();
    n_checks++;
    if (a_dacz !== 1'b1 || a_run !== 1'b0)
      $display("FAIL sr_idle got dacz=%b run=%b want 1,0", a_dacz, a_run);
    else n_pass++;
    push_a(64'hB00, 3'd3, 24'd100);
    start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (a_run !== 1'b1 || a_dacz !== 1'b1)
      $display("FAIL sr_enter got run=%b dacz=%b want 1,1", a_run, a_dacz);
    else n_pass++;
    step();
    n_checks++;
    if (a_dacz !== 1'b0) $display("FAIL sr_dacz_lag got %b want 0", a_dacz);
    else n_pass++;
    for (int k = 2; k <= 50; k++) begin step(); if (ifa.cstrobe) n_str++; end
    stop = 1'b1; step(); stop = 1'b0;
    for (int k = 0; k < 30; k++) begin step(); if (ifa.cstrobe || !a_dacz) n_str++; end
    n_checks++;
    if (n_str != 0 || a_level !== 5'd1)
      $display("FAIL sr_stopped got bad=%0d lvl=%0d want 0,1", n_str, a_level);
    else n_pass++;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 110; k++) begin
      step();
      if (ifa.cstrobe && first_k < 0) first_k = k;
    end
    n_checks++;
    if (first_k != 101) $display("FAIL sr_resume_issue got k=%0d want 101", first_k);
    else n_pass++;
    n_checks++;
    if (ifa.command !== 64'hB00 || ifa.cmda !== 3'd3)
      $display("FAIL sr_hold got cmd=%h cmda=%0d want b00,3", ifa.command, ifa.cmda);
    else n_pass++;
  endtask

  task automatic test_start_stop();
    int n_str = 0;
    stop = 1'b1; step(); stop = 1'b0;
    push_a(64'hC00, 3'd4, 24'd0);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    n_checks++;
    if (a_run !== 1'b0) $display("FAIL ss_running got %b want 0", a_run);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin step(); if (ifa.cstrobe) n_str++; end
    n_checks++;
    if (n_str != 0 || a_level !== 5'd1 || a_dacz !== 1'b1)
      $display("FAIL ss_quiet got str=%0d lvl=%0d dacz=%b want 0,1,1", n_str, a_level, a_dacz);
    else n_pass++;
    flush = 1'b1; step(); flush = 1'b0;
    n_checks++;
    if (a_level !== 5'd0) $display("FAIL ss_flush got lvl=%0d want 0", a_level);
    else n_pass++;
  endtask

  task automatic test_ovf();
    b_start = 1'b1; step(); b_start = 1'b0;
    for (int k = 0; k < 20; k++) step();
    n_checks++;
    if (b_ovf !== 1'b1 || b_run !== 1'b1 || ifb.cstrobe !== 1'b0)
      $display("FAIL ovf_sat got ovf=%b run=%b str=%b want 1,1,0", b_ovf, b_run, ifb.cstrobe);
    else n_pass++;
    ifb.in_valid = 1'b1; ifb.in_cmd = 64'h5A5A; ifb.in_elem = 3'd6; ifb.in_time = 4'd3;
    step();
    ifb.in_valid = 1'b0;
    n_checks++;
    if (ifb.cstrobe !== 1'b0) $display("FAIL ovf_early got str=%b want 0", ifb.cstrobe);
    else n_pass++;
    step();
    n_checks++;
    if (ifb.cstrobe !== 1'b1 || b_late !== 1'b1 || ifb.cmda !== 3'd6 || ifb.command !== 64'h5A5A)
      $display("FAIL ovf_issue got str=%b late=%b cmda=%0d cmd=%h want 1,1,6,5a5a",
               ifb.cstrobe, b_late, ifb.cmda, ifb.command);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    stop = 1'b1; step(); stop = 1'b0;
    push_a(64'hE0, 3'd0, 24'd0);
    push_a(64'hE1, 3'd1, 24'd0);
    for (int i = 0; i < 4; i++) push_a(64'hE2 + 64'(i), 3'd2, 24'd200);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    n_checks++;
    if (a_level !== 5'd4 || a_late !== 1'b1 || a_run !== 1'b1)
      $display("FAIL rm_pre got lvl=%0d late=%b run=%b want 4,1,1", a_level, a_late, a_run);
    else n_pass++;
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++;
    if (a_level !== 5'd0 || {ifa.cstrobe, a_dacz, a_run, a_late} !== 4'b0100)
      $display("FAIL rm_after got lvl=%0d str/dacz/run/late=%b want 0,0100", a_level,
               {ifa.cstrobe, a_dacz, a_run, a_late});
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      ifa.in_valid = 1'($urandom_range(0, 1));
      ifa.in_cmd = {$urandom, $urandom};
      ifa.in_elem = 3'($urandom_range(0, 7));
      ifa.in_time = 24'($urandom_range(0, 80));
      start = ($urandom_range(0, 39) == 0);
      stop = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 69) == 0);
      step();
      n_checks++;
      if ({ifa.cstrobe, ifa.cmda, ifa.command} !== {m_strobe, m_elem, m_cmd})
        $display("FAIL rnd_bus c=%0d got %b/%0d/%h want %b/%0d/%h", c, ifa.cstrobe, ifa.cmda,
                 ifa.command, m_strobe, m_elem, m_cmd);
      else n_pass++;
      n_checks++;
      if ({a_run, a_dacz, a_late, a_ovf} !== {m_run, m_dacz, m_late, m_ovf})
        $display("FAIL rnd_flags c=%0d got %b want %b", c, {a_run, a_dacz, a_late, a_ovf},
                 {m_run, m_dacz, m_late, m_ovf});
      else n_pass++;
      n_checks++;
      if (int'(a_level) != mq.size() || ifa.in_ready !== (mq.size() < 16))
        $display("FAIL rnd_level c=%0d got %0d/%b want %0d/%b", c, a_level, ifa.in_ready,
                 mq.size(), mq.size() < 16);
      else n_pass++;
    end
    ifa.in_valid = 1'b0; start = 1'b0; stop = 1'b0; flush = 1'b0;
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_cmd = '0; ifa.in_elem = '0; ifa.in_time = '0;
    ifb.in_valid = 1'b0; ifb.in_cmd = '0; ifb.in_elem = '0; ifb.in_time = '0;
    test_reset();
    test_order();
    test_fill();
    test_stop_resume();
    test_start_stop();
    test_ovf();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
